// File: rtl/mem_to_axilite_bridge.sv
// MEM request/grant/rvalid to AXI4-Lite master bridge.
// One transaction in flight; AXI valids and captured address/data come
// straight from flops, readies and MEM response decode directly from state.
module mem_to_axilite_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // core-side MEM port
    input  logic                    mem_req_i,
    output logic                    mem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH/8-1:0] mem_be_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    output logic                    mem_valid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_error_o,
    // AXI4-Lite write address
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // AXI4-Lite write data
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // AXI4-Lite read address
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // AXI4-Lite read data
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, RESP} state_t;

    state_t                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0]   be_q,      be_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic                    error_q,   error_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    arvalid_q, arvalid_d;

    // Next-state logic: grant and capture in IDLE, then walk the AXI channels.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    be_d    = mem_be_i;
                    if (mem_we_i) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once both are gone.
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q & ~m_axi_wready;
                if (!awvalid_d && !wvalid_d) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (m_axi_bvalid) begin
                    error_d = |m_axi_bresp;
                    state_d = RESP;
                end
            end
            RD: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = WAIT_R;
                end
            end
            WAIT_R: begin
                // Data is returned even on an error response.
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    error_d = |m_axi_rresp;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops every valid immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign mem_gnt_o     = (state_q == IDLE) & mem_req_i;
    assign mem_valid_o   = (state_q == RESP);
    assign mem_error_o   = (state_q == RESP) & error_q;
    assign mem_rdata_o   = rdata_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = AXI_PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = be_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == WAIT_B);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = AXI_PROT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == WAIT_R);

endmodule

// File: tb/tb_mem_to_axilite_bridge.sv
// Bench for mem_to_axilite_bridge: vector table + AXI slave model with
// programmable ready delays + response scoreboard.
module tb_mem_to_axilite_bridge;

    logic        clk_i, rst_i;
    logic        mem_req_i, mem_gnt_o, mem_we_i, mem_valid_o, mem_error_o;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic [3:0]  mem_be_i;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    mem_to_axilite_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_addr_i(mem_addr_i),
        .mem_we_i(mem_we_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_valid_o(mem_valid_o), .mem_rdata_o(mem_rdata_o), .mem_error_o(mem_error_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;   // data the slave returns on R
        logic [1:0]  resp;    // resp the slave returns on B/R
        int          aw_dly, w_dly, ar_dly;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          gcyc;
        int          lat;
    } entry_t;

    entry_t      sb[$];
    vec_t        vecs[7];
    int          checks = 0, errors = 0, cyc = 0;
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    int          n_ar = 0, n_valid = 0;
    logic        r_stall = 1'b0;
    logic [31:0] last_rd = '0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Record a granted request in the scoreboard with its expected response.
    task automatic grant(input vec_t v);
        entry_t e;
        chk("gnt_while_busy", 64'(sb.size()), 0);
        e.we = v.we; e.addr = v.addr; e.be = v.be; e.wdata = v.wdata;
        e.rdata = v.rdata; e.resp = v.resp;
        e.exp_err = (v.resp != 2'b00);
        if (v.we) begin
            e.exp_rdata = last_rd;
            e.lat = ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 3;
        end else begin
            e.exp_rdata = v.rdata;
            last_rd = v.rdata;
            e.lat = v.ar_dly + 3;
        end
        e.gcyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            chk("resp_timeout", 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic drive(input vec_t v);
        mem_we_i = v.we; mem_addr_i = v.addr; mem_be_i = v.be; mem_wdata_i = v.wdata;
        aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly;
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        @(negedge clk_i);
        drive(v);
        mem_req_i = 1'b1;
        #1;
        while (!mem_gnt_o && n < 50) begin
            @(negedge clk_i); #1; n++;
        end
        if (!mem_gnt_o) chk("gnt_timeout", 0, 1);
        else grant(v);
        @(negedge clk_i);
        mem_req_i = 1'b0;
        wait_done();
    endtask

    // Response monitor: pops the scoreboard on each mem_valid_o pulse.
    logic prev_valid = 1'b0;
    always @(negedge clk_i) begin
        entry_t e;
        if (rst_i) begin
            prev_valid = 1'b0;
        end else begin
            if (!mem_valid_o) chk("err_unqualified", mem_error_o, 0);
            if (mem_valid_o) begin
                n_valid++;
                chk("valid_one_cycle", prev_valid, 0);
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("mem_rdata", mem_rdata_o, e.exp_rdata);
                    chk("mem_error", mem_error_o, e.exp_err);
                    chk("latency", 64'(cyc - e.gcyc), 64'(e.lat));
                end
            end
            prev_valid = mem_valid_o;
        end
    end

    // AXI slave model: inputs change on the falling edge, a handshake is
    // taken on the following rising edge, B/R answer one cycle later.
    int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic aw_done = 0, w_done = 0, ar_done = 0, b_hs = 0, r_hs = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    end
    always @(negedge clk_i) begin
        if (rst_i) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            aw_done = 0; w_done = 0; ar_done = 0; b_hs = 0; r_hs = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (p_awv && !p_awr) begin
                chk("awvalid_hold", m_axi_awvalid, 1);
                chk("awaddr_stable", m_axi_awaddr, p_awaddr);
            end
            if (p_wv && !p_wr) begin
                chk("wvalid_hold", m_axi_wvalid, 1);
                chk("wdata_stable", m_axi_wdata, p_wdata);
                chk("wstrb_stable", m_axi_wstrb, p_wstrb);
            end
            if (p_arv && !p_arr) begin
                chk("arvalid_hold", m_axi_arvalid, 1);
                chk("araddr_stable", m_axi_araddr, p_araddr);
            end
            if (m_axi_bready)
                chk("bready_excl", m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | m_axi_rready, 0);
            if (m_axi_rready)
                chk("rready_excl", m_axi_awvalid | m_axi_wvalid | m_axi_arvalid, 0);

            if (b_hs) begin m_axi_bvalid = 0; b_hs = 0; end
            if (r_hs) begin m_axi_rvalid = 0; r_hs = 0; end
            if (aw_done && w_done && !m_axi_bvalid) begin
                m_axi_bvalid = 1;
                m_axi_bresp  = (sb.size() != 0) ? sb[0].resp : 2'b00;
                aw_done = 0; w_done = 0;
            end
            if (ar_done && !m_axi_rvalid && !r_stall) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = (sb.size() != 0) ? sb[0].rdata : 32'h0;
                m_axi_rresp  = (sb.size() != 0) ? sb[0].resp : 2'b00;
                ar_done = 0;
            end

            if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin m_axi_awready = 0; aw_cnt = 0; end
            if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= w_dly); w_cnt++; end
            else begin m_axi_wready = 0; w_cnt = 0; end
            if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin m_axi_arready = 0; ar_cnt = 0; end

            if (m_axi_awvalid && m_axi_awready) begin
                aw_done = 1;
                if (sb.size() == 0) chk("stray_aw", 1, 0);
                else begin
                    chk("awaddr", m_axi_awaddr, sb[0].addr);
                    chk("awprot", m_axi_awprot, 0);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_done = 1;
                if (sb.size() == 0) chk("stray_w", 1, 0);
                else begin
                    chk("wdata", m_axi_wdata, sb[0].wdata);
                    chk("wstrb", m_axi_wstrb, sb[0].be);
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_done = 1;
                n_ar++;
                if (sb.size() == 0) chk("stray_ar", 1, 0);
                else begin
                    chk("araddr", m_axi_araddr, sb[0].addr);
                    chk("arprot", m_axi_arprot, 0);
                end
            end
            b_hs = m_axi_bvalid && m_axi_bready;
            r_hs = m_axi_rvalid && m_axi_rready;
            p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
            p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
            p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
        end
    end

    initial begin
        vec_t v;
        int   n, ng, ar0, nv0;
        rst_i = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_be_i = '0; mem_wdata_i = '0;

        // reset state
        repeat (2) @(negedge clk_i);
        chk("rst_gnt", mem_gnt_o, 0);
        chk("rst_valid", mem_valid_o, 0);
        chk("rst_error", mem_error_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_axi_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        chk("rst_axi_readies", {m_axi_bready, m_axi_rready}, 0);
        chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 0);
        chk("rst_wdata_strb", {m_axi_wdata, m_axi_wstrb}, 0);
        rst_i = 1'b0;

        // no request: no AXI activity
        repeat (5) begin
            @(negedge clk_i);
            chk("idle_quiet", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                               m_axi_bready, m_axi_rready, mem_valid_o, mem_gnt_o}, 0);
        end

        //            we    addr          be     wdata         rdata         resp  aw w  ar
        vecs[0] = '{1'b0, 32'h1000_0004, 4'hF, 32'h0,        32'hDEAD_BEEF, 2'b00, 0, 0, 0};
        vecs[1] = '{1'b1, 32'h2000_0000, 4'h3, 32'h1234_5678, 32'h0,        2'b00, 0, 3, 0};
        vecs[2] = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,        32'hCAFE_F00D, 2'b11, 0, 0, 0};
        vecs[3] = '{1'b1, 32'h4000_0001, 4'h0, 32'hA5A5_5A5A, 32'h0,        2'b00, 0, 0, 0};
        vecs[4] = '{1'b1, 32'h4000_0100, 4'hC, 32'h0F0F_F0F0, 32'h0,        2'b10, 2, 0, 0};
        vecs[5] = '{1'b0, 32'h5000_0020, 4'hF, 32'h0,        32'h0BAD_C0DE, 2'b00, 0, 0, 10};
        vecs[6] = '{1'b0, 32'h6000_0003, 4'hF, 32'h0,        32'h7777_8888, 2'b10, 0, 0, 0};
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // back-to-back: request held high across two reads
        v = '{1'b0, 32'h7000_0010, 4'hF, 32'h0, 32'h1111_2222, 2'b00, 0, 0, 0};
        ar0 = n_ar; nv0 = n_valid; ng = 0; n = 0;
        @(negedge clk_i);
        drive(v);
        mem_req_i = 1'b1;
        while (ng < 2 && n < 60) begin
            #1;
            if (mem_gnt_o) begin
                grant(v);
                ng++;
                v.rdata = 32'h3333_4444;
            end
            @(negedge clk_i);
            n++;
        end
        mem_req_i = 1'b0;
        chk("b2b_grants", 64'(ng), 2);
        wait_done();
        repeat (3) @(negedge clk_i);
        chk("b2b_ar_count", 64'(n_ar - ar0), 2);
        chk("b2b_valid_count", 64'(n_valid - nv0), 2);

        // reset while waiting on R
        r_stall = 1'b1;
        v = '{1'b0, 32'h8000_0000, 4'hF, 32'h0, 32'h5555_6666, 2'b00, 0, 0, 0};
        @(negedge clk_i);
        drive(v);
        mem_req_i = 1'b1;
        #1;
        if (mem_gnt_o) grant(v);
        else chk("rst_case_gnt", mem_gnt_o, 1);
        @(negedge clk_i);
        mem_req_i = 1'b0;
        n = 0;
        while (!m_axi_rready && n < 20) begin @(negedge clk_i); n++; end
        chk("reached_wait_r", m_axi_rready, 1);
        rst_i = 1'b1;
        #1;
        chk("midrst_arvalid", m_axi_arvalid, 0);
        chk("midrst_rready", m_axi_rready, 0);
        chk("midrst_valid", mem_valid_o, 0);
        chk("midrst_rdata", mem_rdata_o, 0);
        sb.delete();
        last_rd = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        r_stall = 1'b0;
        run_vec('{1'b0, 32'h9000_0004, 4'hF, 32'h0, 32'h2468_ACE0, 2'b00, 0, 0, 0});
        // write after reset: read data register keeps the last read value
        run_vec('{1'b1, 32'h9000_0008, 4'hF, 32'hFFFF_0000, 32'h0, 2'b00, 1, 1, 0});

        repeat (3) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_to_axilite_bridge.md
Name: mem_to_axilite_bridge

Overview:
- Converts the core-side MEM request/grant/rvalid protocol into an AXI4-Lite master.
- Sits directly downstream of the CV32E40P core wrapper's instr/data MEM master ports; one instance per port.
- Feeds the SoC AXI crossbar.
- One outstanding transaction; fully registered AXI outputs.

Parameters:
- ADDR_WIDTH, 32, MEM/AXI address width.
- DATA_WIDTH, 32, MEM/AXI data width (strobe width = DATA_WIDTH/8).
- AXI_PROT, 3'b000, constant driven on awprot/arprot.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- mem_req_i  in  1  request valid
- mem_gnt_o  out  1  request accepted
- mem_addr_i  in  ADDR_WIDTH  byte address
- mem_we_i  in  1  1=write, 0=read
- mem_be_i  in  DATA_WIDTH/8  byte enables
- mem_wdata_i  in  DATA_WIDTH  write data
- mem_valid_o  out  1  response valid (one-cycle pulse)
- mem_rdata_o  out  DATA_WIDTH  read data
- mem_error_o  out  1  response error, qualified by mem_valid_o
- m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1;  m_axi_awready  in  1
- m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1;  m_axi_wready  in  1
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1
- m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1;  m_axi_arready  in  1
- m_axi_rdata  in  DATA_WIDTH;  m_axi_rresp  in  2;  m_axi_rvalid  in  1;  m_axi_rready  out  1

Behaviour:
- Interface: one clock, clk_i; rst_i is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - All *valid/*ready outputs, mem_gnt_o, mem_valid_o and mem_error_o = 0.
  - mem_rdata_o = 0; registered AXI addr/data/strb = 0.
- FSM states: IDLE, WR (AW/W pending), WAIT_B, RD (AR pending), WAIT_R, RESP.
- IDLE:
  - mem_gnt_o = mem_req_i (combinational); no grant in any other state.
  - On gnt, capture addr, we, be, wdata.
  - Next state: WR if we, else RD.
- WR:
  - awvalid and wvalid asserted from the cycle after grant.
  - Each deasserts independently after its own handshake (valid&ready); handshakes may complete in the same or different cycles.
  - When both are done, go to WAIT_B.
  - Address and data stay stable while their valid is high.
- WAIT_B:
  - bready=1.
  - On bvalid: error_q = (bresp != 2'b00); go to RESP.
- RD:
  - arvalid=1 until arready, then WAIT_R.
- WAIT_R:
  - rready=1.
  - On rvalid: mem_rdata_o <= rdata; error_q = (rresp != 2'b00); go to RESP.
- RESP:
  - mem_valid_o=1 and mem_error_o=error_q for exactly one cycle, then IDLE.
  - mem_error_o=0 whenever mem_valid_o=0.
- mem_rdata_o:
  - Updated only on R handshake; holds its value across writes and idle cycles.
  - Read data is returned even on SLVERR/DECERR.
- Data mapping: awaddr/araddr = captured addr unmodified (no alignment); wstrb = captured be; be=0 is forwarded as-is.
- Latency with zero-wait AXI slave:
  - Write: gnt T; AW/W handshake T+1; B at T+2; mem_valid_o at T+3.
  - Read: gnt T; AR T+1; R T+2; mem_valid_o T+3.
  - Next grant at the earliest T+4.
- AXI valid signals never drop before ready; ready signals are never asserted outside WAIT_B/WAIT_R.
- Reset mid-transaction: immediate return to IDLE; all valids/readies deasserted asynchronously; the pending MEM response is lost.
- mem_req_i held low: block idles, no AXI activity.
- Back-to-back requests: the second mem_req_i waits (gnt=0) until IDLE.

Test Plan:
- Read, zero-wait slave: addr=0x1000_0004, rdata=0xDEAD_BEEF, rresp=00 -> araddr=0x1000_0004, mem_valid_o at T+3, mem_rdata_o=0xDEAD_BEEF, mem_error_o=0.
- Write with skewed ready: addr=0x2000_0000, wdata=0x1234_5678, be=4'b0011; awready at T+1, wready at T+4 -> awvalid drops after T+1, wvalid held until T+4 with stable wdata/wstrb=0011, bready only after T+4, mem_valid_o one cycle after B.
- Error response: read with rresp=2'b11 -> mem_valid_o=1, mem_error_o=1, mem_rdata_o=R data; following write with bresp=00 -> mem_error_o=0.
- Back-to-back: req held high for 2 reads -> second gnt not before the cycle after the first mem_valid_o pulse; exactly 2 AR handshakes, exactly 2 one-cycle valid pulses.
- Reset mid-op: assert rst_i while in WAIT_R -> same-cycle arvalid/rready/mem_valid_o=0; after release, a new read completes normally.
- Backpressure: arready low for 10 cycles -> arvalid and araddr stable for 10 cycles, no grant issued, response follows the handshake.
